sb_rx_deser: RTL and testbench

SB_RX_DESER -- requirements
Module: sb_rx_deser

---
 rtl/sb_rx_deser.sv | 161 ++++++++++++++++
 tb/tb_sb_rx_deser.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sb_rx_deser.sv
// Sideband serial receiver: shifts a 64-bit packet in LSB first, presents it
// one cycle after the last bit, and enforces a minimum idle gap between
// packets. Truncated packets and gap violations raise a one-cycle error pulse.
module sb_rx_deser #(
    parameter int GAP_UI = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_ser_vld,
    input  logic        i_ser_data,
    output logic [63:0] o_deser_data,
    output logic        o_deser_done,
    output logic        o_frame_err,
    output logic        o_busy
);

    localparam int GW = $clog2(GAP_UI + 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_UI);
    localparam logic [GW-1:0] GAP_ZERO = '0;
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);
    localparam logic [6:0]    BIT_LAST = 7'd63;
    localparam logic [6:0]    BIT_FULL = 7'd64;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        RESYNC
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [63:0]     shift_q, shift_d;
    logic            done_pend_q, done_pend_d;
    logic [63:0]     data_q, data_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [GW-1:0]   gap_inc;

    // Saturating gap increment; the counter never wraps past GAP_UI.
    always_comb begin
        gap_inc = gap_cnt_q;
        if (gap_cnt_q < GAP_MAX) begin
            gap_inc = gap_cnt_q + GAP_ONE;
        end
    end

    // Next-state, counter, shift register and output computation.
    // A completed packet sets done_pend; the following cycle copies the shift
    // register to the output and pulses done, while the receiver already sits
    // in GAP counting that cycle as the first idle one.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        shift_d     = shift_q;
        done_pend_d = 1'b0;
        data_d      = data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (!i_enable) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
        end else begin
            if (done_pend_q) begin
                data_d = shift_q;
                done_d = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (i_ser_vld) begin
                        shift_d   = {63'b0, i_ser_data};
                        bit_cnt_d = 7'd1;
                        state_d   = SHIFT;
                    end
                end

                SHIFT: begin
                    if (i_ser_vld) begin
                        shift_d[bit_cnt_q[5:0]] = i_ser_data;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d   = BIT_FULL;
                            done_pend_d = 1'b1;
                            gap_cnt_d   = GAP_ZERO;
                            state_d     = GAP;
                        end else if (bit_cnt_q < BIT_FULL) begin
                            bit_cnt_d = bit_cnt_q + 7'd1;
                        end
                    end else begin
                        err_d     = 1'b1;
                        bit_cnt_d = '0;
                        gap_cnt_d = GAP_ZERO;
                        state_d   = GAP;
                    end
                end

                GAP: begin
                    if (i_ser_vld) begin
                        err_d   = 1'b1;
                        state_d = RESYNC;
                    end else begin
                        gap_cnt_d = gap_inc;
                        if (gap_inc >= GAP_MAX) begin
                            state_d = IDLE;
                        end
                    end
                end

                RESYNC: begin
                    if (!i_ser_vld) begin
                        gap_cnt_d = GAP_ONE;
                        state_d   = (GAP_ONE >= GAP_MAX) ? IDLE : GAP;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            shift_q     <= '0;
            done_pend_q <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            shift_q     <= shift_d;
            done_pend_q <= done_pend_d;
            data_q      <= data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign o_deser_data = data_q;
    assign o_deser_done = done_q;
    assign o_frame_err  = err_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_sb_rx_deser.sv
// Self-checking bench for sb_rx_deser: packets are driven LSB first, expected
// payloads are queued as each packet is sent and compared on every done pulse.
module tb_sb_rx_deser;

    localparam int GAP = 32;

    logic        i_clk;
    logic        i_rst;
    logic        i_enable;
    logic        i_ser_vld;
    logic        i_ser_data;
    logic [63:0] o_deser_data;
    logic        o_deser_done;
    logic        o_frame_err;
    logic        o_busy;

    int          vectorCount = 0;
    int          missCount   = 0;
    int          doneSeen    = 0;
    int          errSeen     = 0;
    logic [63:0] expectQ[$];
    logic [63:0] expectedData = '0;

    sb_rx_deser #(.GAP_UI(GAP)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_enable    (i_enable),
        .i_ser_vld   (i_ser_vld),
        .i_ser_data  (i_ser_data),
        .o_deser_data(o_deser_data),
        .o_deser_done(o_deser_done),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    // 10 ns clock
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Hard stop in case the sequence never completes.
    initial begin
        #200us;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point; counts every comparison and reports misses.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drives nbits of pkt LSB first, optionally dropping enable with the
    // last bit; the payload is queued when a done pulse is expected.
    task automatic applyStimulus(input logic [63:0] pkt, input int nbits,
                                 input bit expectDone, input bit dropEnable);
        if (expectDone) expectQ.push_back(pkt);
        for (int i = 0; i < nbits; i++) begin
            i_ser_vld  = 1'b1;
            i_ser_data = pkt[i];
            if (dropEnable && i == nbits - 1) i_enable = 1'b0;
            @(posedge i_clk);
            #1;
        end
        i_ser_vld  = 1'b0;
        i_ser_data = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        i_ser_vld = 1'b0;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Monitor: sample away from the active edge, pop on every done pulse.
    always @(negedge i_clk) begin
        if (o_deser_done === 1'b1) begin
            doneSeen++;
            if (expectQ.size() == 0) begin
                checkOutput("unexpected_done", 64'd1, 64'd0);
            end else begin
                expectedData = expectQ.pop_front();
                checkOutput("done_data", o_deser_data, expectedData);
            end
        end
        if (o_frame_err === 1'b1) errSeen++;
    end

    initial begin
        int d0, e0;

        i_rst      = 1'b1;
        i_enable   = 1'b1;
        i_ser_vld  = 1'b0;
        i_ser_data = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        checkOutput("rst_data", o_deser_data, 64'h0);
        checkOutput("rst_done", {63'b0, o_deser_done}, 64'd0);
        checkOutput("rst_err",  {63'b0, o_frame_err}, 64'd0);
        checkOutput("rst_busy", {63'b0, o_busy}, 64'd0);
        idleCycles(2);

        // Basic packet with exact one-cycle latency and a single-cycle pulse.
        e0 = errSeen;
        applyStimulus(64'hA5A5_0000_1234_5678, 64, 1'b1, 1'b0);
        @(negedge i_clk);
        checkOutput("done_early", {63'b0, o_deser_done}, 64'd0);
        @(negedge i_clk);
        checkOutput("done_latency", {63'b0, o_deser_done}, 64'd1);
        checkOutput("data_basic", o_deser_data, 64'hA5A5_0000_1234_5678);
        @(negedge i_clk);
        checkOutput("done_width", {63'b0, o_deser_done}, 64'd0);
        checkOutput("err_basic", 64'(errSeen - e0), 64'd0);
        idleCycles(GAP + 4);

        // Two packets with exactly the minimum gap: both accepted.
        d0 = doneSeen; e0 = errSeen;
        applyStimulus(64'h0123_4567_89AB_CDEF, 64, 1'b1, 1'b0);
        idleCycles(GAP);
        applyStimulus(64'hFEDC_BA98_7654_3210, 64, 1'b1, 1'b0);
        idleCycles(GAP + 8);
        checkOutput("gap32_done", 64'(doneSeen - d0), 64'd2);
        checkOutput("gap32_err", 64'(errSeen - e0), 64'd0);

        // One cycle short of the gap: second packet rejected with an error.
        d0 = doneSeen; e0 = errSeen;
        applyStimulus(64'h1111_2222_3333_4444, 64, 1'b1, 1'b0);
        idleCycles(GAP - 1);
        applyStimulus(64'h5555_6666_7777_8888, 64, 1'b0, 1'b0);
        idleCycles(GAP + 8);
        checkOutput("gap31_done", 64'(doneSeen - d0), 64'd1);
        checkOutput("gap31_err", 64'(errSeen - e0), 64'd1);
        checkOutput("gap31_data", o_deser_data, expectedData);

        // Truncated packet after 40 bits, then a normal packet.
        d0 = doneSeen; e0 = errSeen;
        applyStimulus(64'hDEAD_BEEF_CAFE_F00D, 40, 1'b0, 1'b0);
        idleCycles(3);
        checkOutput("trunc_err", 64'(errSeen - e0), 64'd1);
        checkOutput("trunc_done", 64'(doneSeen - d0), 64'd0);
        checkOutput("trunc_data", o_deser_data, expectedData);
        idleCycles(GAP + 4);
        applyStimulus(64'h0F0F_F0F0_3C3C_C3C3, 64, 1'b1, 1'b0);
        idleCycles(GAP + 4);
        checkOutput("trunc_recover", 64'(doneSeen - d0), 64'd1);

        // Enable drops with the 64th bit: packet discarded.
        d0 = doneSeen; e0 = errSeen;
        applyStimulus(64'h7E7E_7E7E_8181_8181, 64, 1'b0, 1'b1);
        @(negedge i_clk);
        checkOutput("en_busy", {63'b0, o_busy}, 64'd0);
        idleCycles(3);
        checkOutput("en_done", 64'(doneSeen - d0), 64'd0);
        checkOutput("en_err", 64'(errSeen - e0), 64'd0);
        checkOutput("en_data", o_deser_data, expectedData);
        i_enable = 1'b1;
        idleCycles(4);

        // Reset at bit 20, then a packet starting one cycle after release.
        d0 = doneSeen; e0 = errSeen;
        applyStimulus(64'hAAAA_5555_AAAA_5555, 20, 1'b0, 1'b0);
        i_rst      = 1'b1;
        i_ser_vld  = 1'b1;
        i_ser_data = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst     = 1'b0;
        i_ser_vld = 1'b0;
        expectedData = '0;
        @(negedge i_clk);
        checkOutput("mrst_data", o_deser_data, 64'h0);
        checkOutput("mrst_done", {63'b0, o_deser_done}, 64'd0);
        checkOutput("mrst_err",  {63'b0, o_frame_err}, 64'd0);
        checkOutput("mrst_busy", {63'b0, o_busy}, 64'd0);
        applyStimulus(64'h9876_5432_10FE_DCBA, 64, 1'b1, 1'b0);
        idleCycles(GAP + 4);
        checkOutput("mrst_done_cnt", 64'(doneSeen - d0), 64'd1);
        checkOutput("mrst_err_cnt", 64'(errSeen - e0), 64'd0);

        // All-ones then all-zeros to expose bit ordering at both extremes.
        d0 = doneSeen;
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1, 1'b0);
        idleCycles(GAP);
        applyStimulus(64'h0, 64, 1'b1, 1'b0);
        idleCycles(GAP + 4);
        checkOutput("ext_done", 64'(doneSeen - d0), 64'd2);
        checkOutput("ext_data", o_deser_data, 64'h0);

        checkOutput("queue_empty", 64'(expectQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
